// File: rtl/spi_dev_reg_bridge.sv
// SPI mode-0 target that turns WRITE (0x02) / READ (0x03) frames into 32-bit register-bus accesses.
// Optional feature macro: SPI_DEV_REG_BRIDGE_STATUS_EN appends a {6'b0, timeout, error} STATUS byte.
package spi_dev_reg_bridge_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module spi_dev_reg_bridge #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned SyncStages = 2,
  parameter type reg_req_t = spi_dev_reg_bridge_pkg::reg_req_t,
  parameter type reg_rsp_t = spi_dev_reg_bridge_pkg::reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     sck_i,
  input  logic     csb_i,
  input  logic     mosi_i,
  output logic     miso_o,
  output logic     miso_en_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     busy_o
);
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] CMD    = 4'd1;
  localparam logic [3:0] ADDR   = 4'd2;
  localparam logic [3:0] WDATA  = 4'd3;
  localparam logic [3:0] BUS_WR = 4'd4;
  localparam logic [3:0] RD_REQ = 4'd5;
  localparam logic [3:0] DUMMY  = 4'd6;
  localparam logic [3:0] RDATA  = 4'd7;
  localparam logic [3:0] DRAIN  = 4'd8;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
  localparam logic [3:0] STATUS = 4'd9;
  localparam logic [3:0] TAIL   = STATUS;
`else
  localparam logic [3:0] TAIL   = DRAIN;
`endif
  localparam logic [31:0] AddrMask = (AddrWidth >= 32) ? 32'hFFFF_FFFF : ((32'h1 << AddrWidth) - 32'h1);
  localparam logic [31:0] BadData  = 32'hBADC_AB1E;

  logic [SyncStages-1:0] sck_sync_q, csb_sync_q, mosi_sync_q;
  logic sck_prev_q, csb_prev_q;
  logic sck_s, csb_s, mosi_s, sck_rise, sck_fall, csb_rise, csb_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      csb_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      csb_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SyncStages-2:0], sck_i};
      csb_sync_q  <= {csb_sync_q[SyncStages-2:0], csb_i};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      csb_prev_q  <= csb_s;
    end
  end

  assign sck_s    = sck_sync_q[SyncStages-1];
  assign csb_s    = csb_sync_q[SyncStages-1];
  assign mosi_s   = mosi_sync_q[SyncStages-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csb_rise = csb_s & ~csb_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;

  logic [3:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d, sh_next, out_sh_q, out_sh_d;
  logic [31:0] fr_addr_q, fr_addr_d, fr_wdata_q, fr_wdata_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
  logic is_wr_q, is_wr_d, bus_wr_q, bus_wr_d, valid_q, valid_d, owner_q, owner_d;
  logic pend_q, pend_d, done_q, done_d, err_q, err_d, issue;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
  logic       timeout_q, timeout_d;
  logic [2:0] sbit_q, sbit_d;
  logic [7:0] status_byte;
  // A write that is still waiting on the bus reports 0x02 until ready arrives.
  assign status_byte = (is_wr_q && !done_q) ? 8'h02 : {6'b0, timeout_q, done_q & err_q};
`endif

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  sh_d = sh_q;  out_sh_d = out_sh_q;  is_wr_d = is_wr_q;
    fr_addr_d = fr_addr_q;  fr_wdata_d = fr_wdata_q;
    bus_addr_d = bus_addr_q;  bus_wdata_d = bus_wdata_q;  bus_wr_d = bus_wr_q;
    valid_d = valid_q;  owner_d = owner_q;  pend_d = pend_q;
    done_d = done_q;  err_d = err_q;  rdata_d = rdata_q;
    issue = 1'b0;
    sh_next = {sh_q[30:0], mosi_s};
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
    timeout_d = timeout_q;
    sbit_d    = sbit_q;
`endif

    // Results are kept only while the frame that launched the access is still open.
    if (valid_q && reg_rsp_i.ready) begin
      valid_d = 1'b0;
      owner_d = 1'b0;
      if (owner_q) begin
        done_d  = 1'b1;
        err_d   = reg_rsp_i.error;
        rdata_d = reg_rsp_i.rdata;
      end
    end

    if (csb_rise) begin
      state_d = IDLE;
      owner_d = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (sck_rise) begin
        sh_d  = sh_next;
        cnt_d = cnt_q + 6'd1;
      end
      case (state_q)
        IDLE: if (csb_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (sck_rise && cnt_q == 6'd7) begin
          cnt_d = '0;
          if (sh_next[7:1] == 7'b0000001) begin
            state_d = ADDR;
            is_wr_d = ~sh_next[0];
          end else begin
            state_d = DRAIN;
          end
        end
        ADDR: if (sck_rise && cnt_q == 6'd31) begin
          cnt_d     = '0;
          fr_addr_d = sh_next & AddrMask;
          if (is_wr_q) begin
            state_d = WDATA;
          end else begin
            state_d = RD_REQ;
            issue   = 1'b1;
          end
        end
        WDATA: if (sck_rise && cnt_q == 6'd31) begin
          cnt_d      = '0;
          fr_wdata_d = sh_next;
          state_d    = BUS_WR;
          issue      = 1'b1;
        end
        BUS_WR: begin
          state_d = TAIL;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
          sbit_d = '0;
`endif
        end
        RD_REQ: state_d = DUMMY;
        DUMMY: if (sck_rise && cnt_q == 6'd7) begin
          cnt_d    = '0;
          state_d  = RDATA;
          out_sh_d = (done_q && !err_q) ? rdata_q : BadData;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
          timeout_d = ~done_q;
`endif
        end
        RDATA: begin
          // The first fall after entering RDATA keeps bit 31 on the pin for the host's next rise.
          if (sck_fall && cnt_q != 6'd0) out_sh_d = {out_sh_q[30:0], 1'b0};
          if (sck_rise && cnt_q == 6'd31) begin
            cnt_d   = '0;
            state_d = TAIL;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
            sbit_d = '0;
`endif
          end
        end
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
        STATUS: begin
          if (sck_fall && cnt_q != 6'd0) sbit_d = sbit_q + 3'd1;
          if (sck_rise && cnt_q == 6'd7) state_d = DRAIN;
        end
`endif
        default: ;
      endcase
    end

    if (issue) begin
      done_d = 1'b0;
      err_d  = 1'b0;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
      timeout_d = 1'b0;
`endif
    end
    // A new access waits until the previous one (possibly from an earlier frame) has retired.
    if ((issue || (pend_q && !csb_rise)) && !valid_q) begin
      valid_d     = 1'b1;
      owner_d     = 1'b1;
      pend_d      = 1'b0;
      bus_addr_d  = fr_addr_d;
      bus_wr_d    = is_wr_q;
      bus_wdata_d = is_wr_q ? fr_wdata_d : '0;
    end else if (issue) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;  cnt_q <= '0;  sh_q <= '0;  out_sh_q <= '0;  is_wr_q <= 1'b0;
      fr_addr_q <= '0;  fr_wdata_q <= '0;  bus_addr_q <= '0;  bus_wdata_q <= '0;  bus_wr_q <= 1'b0;
      valid_q <= 1'b0;  owner_q <= 1'b0;  pend_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
      rdata_q <= '0;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
      timeout_q <= 1'b0;  sbit_q <= '0;
`endif
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  sh_q <= sh_d;  out_sh_q <= out_sh_d;  is_wr_q <= is_wr_d;
      fr_addr_q <= fr_addr_d;  fr_wdata_q <= fr_wdata_d;  bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;  bus_wr_q <= bus_wr_d;
      valid_q <= valid_d;  owner_q <= owner_d;  pend_q <= pend_d;  done_q <= done_d;  err_q <= err_d;
      rdata_q <= rdata_d;
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
      timeout_q <= timeout_d;  sbit_q <= sbit_d;
`endif
    end
  end

  always_comb begin
    miso_en_o = (state_q == DUMMY) || (state_q == RDATA);
    miso_o    = (state_q == RDATA) && out_sh_q[31];
`ifdef SPI_DEV_REG_BRIDGE_STATUS_EN
    if (state_q == STATUS) begin
      miso_en_o = 1'b1;
      miso_o    = status_byte[3'd7 - sbit_q];
    end
`endif
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = bus_addr_q;
    reg_req_o.write = bus_wr_q;
    reg_req_o.wdata = bus_wdata_q;
    reg_req_o.wstrb = {4{valid_q}};
    reg_req_o.valid = valid_q;
  end

  assign busy_o = (state_q != IDLE) && (state_q != CMD);

endmodule
